// File: rtl/mmu_requester_pkg.sv
// Shared constants, state codes and request bundle for mmu_requester.
// MMU command/error codes plus local LSU fault causes.
package mmu_requester_pkg;

  localparam logic [3:0] MMU_READ  = 4'h1;
  localparam logic [3:0] MMU_WRITE = 4'h2;
  localparam logic [3:0] MMU_SPAG  = 4'h3;
  localparam logic [3:0] MMU_PDIR  = 4'h4;

  localparam logic [3:0] MMU_NOERR  = 4'h0;
  localparam logic [3:0] MMU_BADCMD = 4'h1;
  localparam logic [3:0] MMU_FRPAGE = 4'h2;
  localparam logic [3:0] MMU_FWPAGE = 4'h3;

  localparam logic [3:0] LSU_MISALIGN = 4'h8;
  localparam logic [3:0] LSU_BADSIZE  = 4'h9;
  localparam logic [3:0] LSU_TIMEOUT  = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAITLOW,
    ST_WAITHI,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
  } req_t;

  function automatic logic [3:0] local_cause(
    input logic [1:0] size,
    input logic [1:0] lsb
  );
    logic [3:0] c;
    c = MMU_NOERR;
    unique case (1'b1)
      size == 2'b10:                     c = LSU_BADSIZE;
      size == 2'b01 && lsb[0]:           c = LSU_MISALIGN;
      size == 2'b11 && lsb != 2'b00:     c = LSU_MISALIGN;
      default:                           c = MMU_NOERR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mmu_requester_load_extend.sv
// Load data extraction: byte/half zero or sign extension, word passthrough.
// Purely combinational.
module mmu_load_extend (
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] result
);

  // Select lane by size and extend
  always_comb begin
    result = data;
    unique case (size)
      2'b00:   result = {{24{sgn & data[7]}}, data[7:0]};
      2'b01:   result = {{16{sgn & data[15]}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mmu_requester.sv
// CPU-side MMU command initiator with local size/alignment checks.
// Optional MMU_TIMEOUT_EN aborts a silent MMU after TIMEOUT_CYCLES.
module mmu_requester
  import mmu_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [3:0]  i_cmd,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic        i_user,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [3:0]  o_cause,
  output logic [31:0] o_fault_addr,
  output logic [31:0] o_mmu_vaddr,
  output logic [31:0] o_mmu_data,
  output logic [1:0]  o_mmu_size,
  output logic [3:0]  o_mmu_cmd,
  output logic        o_mmu_valid,
  output logic        o_mmu_user,
  input  logic [31:0] i_mmu_data,
  input  logic        i_mmu_valid,
  input  logic [3:0]  i_mmu_error
);

  state_e      state, state_n;
  req_t        req_q;
  logic [3:0]  err_q;
  logic [31:0] rdat_q;
  logic [31:0] ext_data;
  logic [3:0]  lcause;
  logic        tmo;
  logic        fault;

  assign lcause = local_cause(i_size, i_addr[1:0]);
  assign fault  = (err_q != MMU_NOERR);

  mmu_load_extend u_ext (
    .data   (rdat_q),
    .size   (req_q.size),
    .sgn    (req_q.sgn),
    .result (ext_data)
  );

`ifdef MMU_TIMEOUT_EN
  logic [15:0] cnt;

  // Cycle counter for time spent waiting on the MMU
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt <= '0;
    else if (state == ST_WAITLOW || state == ST_WAITHI)
      cnt <= cnt + 16'd1;
    else
      cnt <= '0;
  end

  assign tmo = (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (i_req)
          state_n = (lcause == MMU_NOERR) ? ST_WAITLOW : ST_DONE;
      ST_WAITLOW:
        if (!i_mmu_valid) state_n = ST_WAITHI;
        else if (tmo)     state_n = ST_DONE;
      ST_WAITHI:
        if (i_mmu_valid || tmo) state_n = ST_DONE;
      ST_DONE:
        state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // Request capture, MMU drive, response capture and completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q        <= '0;
      err_q        <= MMU_NOERR;
      rdat_q       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_rdata      <= '0;
      o_fault      <= 1'b0;
      o_cause      <= MMU_NOERR;
      o_fault_addr <= '0;
      o_mmu_vaddr  <= '0;
      o_mmu_data   <= '0;
      o_mmu_size   <= '0;
      o_mmu_cmd    <= '0;
      o_mmu_valid  <= 1'b0;
      o_mmu_user   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_req) begin
            req_q  <= '{cmd: i_cmd, addr: i_addr, size: i_size, sgn: i_signed};
            err_q  <= lcause;
            rdat_q <= '0;
            o_busy <= 1'b1;
            if (lcause == MMU_NOERR) begin
              o_mmu_vaddr <= i_addr;
              o_mmu_data  <= i_wdata;
              o_mmu_size  <= i_size;
              o_mmu_cmd   <= i_cmd;
              o_mmu_user  <= i_user;
              o_mmu_valid <= 1'b1;
            end
          end
        end
        ST_WAITLOW: begin
          if (i_mmu_valid && tmo) begin
            err_q       <= LSU_TIMEOUT;
            o_mmu_valid <= 1'b0;
          end
        end
        ST_WAITHI: begin
          if (i_mmu_valid) begin
            rdat_q      <= i_mmu_data;
            err_q       <= i_mmu_error;
            o_mmu_valid <= 1'b0;
          end else if (tmo) begin
            err_q       <= LSU_TIMEOUT;
            o_mmu_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          o_done       <= 1'b1;
          o_busy       <= 1'b0;
          o_fault      <= fault;
          o_cause      <= err_q;
          o_fault_addr <= fault ? req_q.addr : '0;
          o_rdata      <= (!fault && req_q.cmd == MMU_READ) ? ext_data : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_requester.sv
// Self-checking bench for mmu_requester with a behavioural MMU responder.
// Expected completions come from a specification-level model.
module tb_mmu_requester;
  import mmu_requester_pkg::*;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [3:0]  i_cmd = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [1:0]  i_size = '0;
  logic        i_signed = 1'b0;
  logic        i_user = 1'b0;
  logic        o_busy, o_done, o_fault, o_mmu_valid, o_mmu_user;
  logic [31:0] o_rdata, o_fault_addr, o_mmu_vaddr, o_mmu_data;
  logic [3:0]  o_cause, o_mmu_cmd;
  logic [1:0]  o_mmu_size;
  logic [31:0] i_mmu_data = '0;
  logic        i_mmu_valid = 1'b0;
  logic [3:0]  i_mmu_error = '0;

  mmu_requester #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_cmd(i_cmd),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size),
    .i_signed(i_signed), .i_user(i_user), .o_busy(o_busy),
    .o_done(o_done), .o_rdata(o_rdata), .o_fault(o_fault),
    .o_cause(o_cause), .o_fault_addr(o_fault_addr),
    .o_mmu_vaddr(o_mmu_vaddr), .o_mmu_data(o_mmu_data),
    .o_mmu_size(o_mmu_size), .o_mmu_cmd(o_mmu_cmd),
    .o_mmu_valid(o_mmu_valid), .o_mmu_user(o_mmu_user),
    .i_mmu_data(i_mmu_data), .i_mmu_valid(i_mmu_valid),
    .i_mmu_error(i_mmu_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  cause;
    logic [31:0] faddr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mmu_ok = 1'b0;
  logic [31:0] x_addr, x_wdata;
  logic [1:0]  x_size;
  logic [3:0]  x_cmd;
  logic        x_user;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic exp_t model(
    input logic [3:0] cmd, input logic [31:0] addr,
    input logic [1:0] size, input logic sgn,
    input logic [31:0] mdata, input logic [3:0] merr, input bit resp);
    exp_t e;
    longint v;
    logic [3:0] c;
    if (size == 2'b10) c = LSU_BADSIZE;
    else if ((size == 2'b01 && addr % 2 != 0) ||
             (size == 2'b11 && addr % 4 != 0)) c = LSU_MISALIGN;
    else if (!resp) c = LSU_TIMEOUT;
    else c = merr;
    e.fault = (c != MMU_NOERR);
    e.cause = c;
    e.faddr = e.fault ? addr : 32'h0;
    e.rdata = '0;
    if (!e.fault && cmd == MMU_READ) begin
      v = mdata;
      if (size == 2'b00) begin
        v = v % 256;
        if (sgn && v >= 128) v = v - 256;
      end else if (size == 2'b01) begin
        v = v % 65536;
        if (sgn && v >= 32768) v = v - 65536;
      end
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  // Compare DUT against the model on every meaningful cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(o_done), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rdata", o_rdata, e.rdata);
          chk("fault", 32'(o_fault), 32'(e.fault));
          chk("cause", 32'(o_cause), 32'(e.cause));
          if (e.fault) chk("fault_addr", o_fault_addr, e.faddr);
        end
      end
      if (o_mmu_valid) begin
        if (!mmu_ok) begin
          chk("mmu_valid_local_fault", 32'(o_mmu_valid), 32'h0);
        end else begin
          chk("mmu_vaddr", o_mmu_vaddr, x_addr);
          chk("mmu_data", o_mmu_data, x_wdata);
          chk("mmu_ctl", {25'h0, x_user, x_size, x_cmd},
              {25'h0, o_mmu_user, o_mmu_size, o_mmu_cmd});
        end
      end
    end
  end

  task automatic run(
    input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [1:0] size, input logic sgn, input logic user,
    input logic [31:0] mdata, input logic [3:0] merr,
    input int stale, input int lat, input bit resp, input int want_lat);
    exp_t e;
    int t0;
    bit local_f;
    bit got;
    e = model(cmd, addr, size, sgn, mdata, merr, resp);
    local_f = (e.cause == LSU_BADSIZE || e.cause == LSU_MISALIGN);
    exp_q.push_back(e);
    mmu_ok = !local_f;
    x_addr = addr; x_wdata = wdata; x_size = size;
    x_cmd = cmd; x_user = user;
    @(negedge clk);
    t0 = cyc;
    i_req = 1'b1; i_cmd = cmd; i_addr = addr; i_wdata = wdata;
    i_size = size; i_signed = sgn; i_user = user;
    if (stale > 0) begin
      i_mmu_valid = 1'b1; i_mmu_data = 32'h1234_5678;
      i_mmu_error = MMU_NOERR;
    end
    @(negedge clk);
    i_req = 1'b0;
    chk("busy_after_req", 32'(o_busy), 32'h1);
    if (!local_f && resp) begin
      repeat ((stale > 1) ? stale - 1 : 0) @(negedge clk);
      i_mmu_valid = 1'b0;
      repeat (lat + 1) @(negedge clk);
      i_mmu_valid = 1'b1; i_mmu_data = mdata; i_mmu_error = merr;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (!o_mmu_valid) break;
      end
      i_mmu_valid = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge clk);
      if (o_done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'h1);
    if (got) begin
      if (want_lat >= 0) chk("latency", 32'(cyc - t0), 32'(want_lat));
      chk("mmu_valid_at_done", 32'(o_mmu_valid), 32'h0);
      chk("busy_at_done", 32'(o_busy), 32'h0);
    end else begin
      exp_q.delete();
    end
    mmu_ok = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {27'h0, o_busy, o_done, o_fault, o_mmu_valid, o_mmu_user},
        32'h0);
    chk({nm, "_cause"}, {24'h0, o_cause, o_mmu_cmd}, 32'h0);
    chk({nm, "_rdata"}, o_rdata, 32'h0);
    chk({nm, "_faddr"}, o_fault_addr, 32'h0);
    chk({nm, "_vaddr"}, o_mmu_vaddr, 32'h0);
    chk({nm, "_mdata"}, o_mmu_data | 32'(o_mmu_size), 32'h0);
  endtask

  initial begin
    exp_t p;
    p = model(MMU_READ, 32'h1003, 2'b00, 1'b1, 32'h80, MMU_NOERR, 1'b1);
    chk("pin_sbyte", p.rdata, 32'hFFFF_FF80);
    p = model(MMU_READ, 32'h1002, 2'b01, 1'b1, 32'hABCD_8001, MMU_NOERR, 1'b1);
    chk("pin_shalf", p.rdata, 32'hFFFF_8001);
    p = model(MMU_READ, 32'h1001, 2'b01, 1'b0, 32'h0, MMU_NOERR, 1'b1);
    chk("pin_misalign", 32'(p.cause), 32'(LSU_MISALIGN));

    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    run(MMU_READ, 32'h1000, 32'h0, 2'b11, 1'b0, 1'b0,
        32'hDEAD_BEEF, MMU_NOERR, 0, 0, 1'b1, 4);
    run(MMU_READ, 32'h1003, 32'h0, 2'b00, 1'b1, 1'b1,
        32'h0000_0080, MMU_NOERR, 0, 0, 1'b1, 4);
    run(MMU_READ, 32'h1003, 32'h0, 2'b00, 1'b0, 1'b1,
        32'h0000_0080, MMU_NOERR, 0, 1, 1'b1, 5);
    run(MMU_READ, 32'h1002, 32'h0, 2'b01, 1'b1, 1'b0,
        32'hABCD_8001, MMU_NOERR, 0, 0, 1'b1, 4);
    run(MMU_READ, 32'h1002, 32'h0, 2'b01, 1'b0, 1'b0,
        32'hABCD_8001, MMU_NOERR, 0, 0, 1'b1, 4);
    run(MMU_READ, 32'h1001, 32'h0, 2'b01, 1'b0, 1'b0,
        32'h0, MMU_NOERR, 0, 0, 1'b1, 2);
    run(MMU_READ, 32'h1002, 32'h0, 2'b11, 1'b0, 1'b0,
        32'h0, MMU_NOERR, 0, 0, 1'b1, 2);
    run(MMU_WRITE, 32'h1004, 32'h55, 2'b10, 1'b0, 1'b0,
        32'h0, MMU_NOERR, 0, 0, 1'b1, 2);
    run(MMU_WRITE, 32'h2008, 32'hCAFE_F00D, 2'b11, 1'b0, 1'b1,
        32'h0, MMU_FWPAGE, 3, 0, 1'b1, 6);
    run(MMU_READ, 32'h3000, 32'h0, 2'b11, 1'b0, 1'b1,
        32'h7777_7777, MMU_FRPAGE, 0, 2, 1'b1, 6);
    run(MMU_SPAG, 32'h0, 32'h1, 2'b11, 1'b0, 1'b0,
        32'hFFFF_FFFF, MMU_NOERR, 0, 0, 1'b1, 4);
    run(MMU_PDIR, 32'h0004_0000, 32'h0, 2'b11, 1'b0, 1'b0,
        32'h1111_2222, MMU_NOERR, 1, 2, 1'b1, 6);

    mmu_ok = 1'b1;
    x_addr = 32'h4000; x_wdata = 32'h0; x_size = 2'b11;
    x_cmd = MMU_READ; x_user = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_cmd = MMU_READ; i_addr = 32'h4000;
    i_wdata = 32'h0; i_size = 2'b11; i_signed = 1'b0; i_user = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("waithi_mmu_valid", 32'(o_mmu_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    mmu_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_in_reset", 32'(o_done), 32'h0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 32'(o_busy | o_done), 32'h0);
    run(MMU_READ, 32'h4000, 32'h0, 2'b11, 1'b0, 1'b1,
        32'h0BAD_F00D, MMU_NOERR, 0, 0, 1'b1, 4);

`ifdef MMU_TIMEOUT_EN
    run(MMU_READ, 32'h5000, 32'h0, 2'b11, 1'b0, 1'b0,
        32'h0, MMU_NOERR, 0, 0, 1'b0, TMO + 2);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
